// File: rtl/mult_ctrl_hilo.sv
// mult_ctrl_hilo
// ---------------------------------------------------------------------------
// Sequencer and HI/LO result register for a 32-step shift-add unsigned
// multiplier. A MULTU request latches the operands, pulses the multiplier's
// load control for one cycle, then issues STEPS step cycles. The 64-bit
// product is then captured into HI/LO, and MFHI/MFLO reads are served.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   reset       asynchronous, active-low reset
//   start       request strobe
//   funct       function code (MULTU / MFHI / MFLO)
//   dataA       multiplicand, sampled with an accepted start
//   dataB       multiplier operand, sampled with an accepted start
//   product     64-bit result bus from the multiplier
//   mul_dataA   registered operand A to the multiplier
//   mul_dataB   registered operand B to the multiplier
//   mul_reset   active-high load pulse to the multiplier
//   mul_signal  multiplier control code (MULTU while stepping, OUT otherwise)
//   busy        high while a multiply is in flight
//   done        one-cycle pulse when HI/LO hold a new result
//   hi, lo      architectural HI/LO registers
//   dataOut     MFHI/MFLO read data (combinational from funct)
// ---------------------------------------------------------------------------
module mult_ctrl_hilo #(
  parameter int STEPS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [63:0] product,
  output logic [31:0] mul_dataA,
  output logic [31:0] mul_dataB,
  output logic        mul_reset,
  output logic [5:0]  mul_signal,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] dataOut
);

  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] SIG_MULTU   = 6'b011001;
  localparam logic [5:0] SIG_OUT     = 6'b111111;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOAD    = 2'd1;
  localparam logic [1:0] RUN     = 2'd2;
  localparam logic [1:0] CAPTURE = 2'd3;

  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  logic [1:0]    state;
  logic [CW-1:0] counter;

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values; blocking here would create ordering
  // races between the state, counter and operand updates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      counter   <= '0;
      mul_dataA <= '0;
      mul_dataB <= '0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
    end else begin
      // done is a single-cycle pulse; only the CAPTURE exit raises it.
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Non-MULTU starts are ignored; operands only move on acceptance.
          if (start && (funct == FUNCT_MULTU)) begin
            mul_dataA <= dataA;
            mul_dataB <= dataB;
            state     <= LOAD;
          end
        end
        LOAD: begin
          counter <= '0;
          state   <= RUN;
        end
        RUN: begin
          // The edge leaving RUN is itself the last step edge, so the
          // multiplier sees exactly STEPS steps (counter values 0..STEPS-1).
          counter <= counter + 1'b1;
          if (counter == LAST_STEP) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          hi    <= product[63:32];
          lo    <= product[31:0];
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Control decode is purely a function of state, so no input reaches
  // these outputs combinationally.
  assign busy       = (state != IDLE);
  assign mul_reset  = (state == LOAD);
  assign mul_signal = (state == RUN) ? SIG_MULTU : SIG_OUT;

  // Read port: returns the last captured result in any state, including
  // while a new multiply is in flight.
  // NOTE: dataOut gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    dataOut = '0;
    case (funct)
      FUNCT_MFHI: dataOut = hi;
      FUNCT_MFLO: dataOut = lo;
      default:    dataOut = '0;
    endcase
  end

endmodule

// File: tb/tb_mult_ctrl_hilo.sv
// Testbench for mult_ctrl_hilo. Includes a behavioural shift-add multiplier
// driven by mul_reset/mul_signal, so a wrong number of load or step cycles
// corrupts the product. Expected HI/LO values are pushed to a scoreboard
// when a MULTU is issued and popped when done is observed.
module tb_mult_ctrl_hilo;

  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] SIG_OUT = 6'b111111;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] dataA, dataB;
  logic [63:0] product;
  logic [31:0] mul_dataA, mul_dataB;
  logic        mul_reset;
  logic [5:0]  mul_signal;
  logic        busy, done;
  logic [31:0] hi, lo, dataOut;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] sb[$];

  mult_ctrl_hilo #(.STEPS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .funct      (funct),
    .dataA      (dataA),
    .dataB      (dataB),
    .product    (product),
    .mul_dataA  (mul_dataA),
    .mul_dataB  (mul_dataB),
    .mul_reset  (mul_reset),
    .mul_signal (mul_signal),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .dataOut    (dataOut)
  );

  always #5 clk = ~clk;

  // Behavioural 32-step shift-add multiplier: {acc_hi, acc_lo} starts as
  // {0, B}; each step adds A to the upper half when lo[0] is set, then
  // shifts the 65-bit result right by one.
  logic [63:0] acc;
  logic [32:0] sum;
  always @(posedge clk) begin
    if (mul_reset === 1'b1) begin
      acc <= {32'b0, mul_dataB};
    end else if (mul_signal === F_MULTU) begin
      sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mul_dataA} : 33'b0);
      acc <= {sum, acc[31:1]};
    end
  end
  assign product = acc;

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  logic [63:0] exp_v;
  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_done: got hi=%h lo=%h, expected no result", hi, lo);
      end else begin
        exp_v = sb.pop_front();
        if ({hi, lo} !== exp_v) begin
          n_fail++;
          $display("FAIL sb_result: got %h_%h, expected %h_%h",
                   hi, lo, exp_v[63:32], exp_v[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives a start for one edge; caller is positioned away from posedge.
  task automatic do_start(input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] f, input bit push);
    start = 1'b1;
    funct = f;
    dataA = a;
    dataB = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    funct = 6'b0;
    dataA = $urandom;
    dataB = $urandom;
    if (push) sb.push_back(64'(a) * 64'(b));
  endtask

  // Called #1 after E0; returns at the negedge where done is seen.
  // lat is the number of edges after E0, or -1 if the bound expired.
  task automatic run_to_done(output int lat, output int rst_cnt, output int run_cnt);
    lat = 0;
    rst_cnt = 0;
    run_cnt = 0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) break;
      if (mul_reset === 1'b1) rst_cnt++;
      if (mul_signal === F_MULTU) run_cnt++;
      @(posedge clk);
      lat++;
      if (lat > 100) begin
        lat = -1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    funct = 6'b0;
    dataA = '0;
    dataB = '0;
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, mul_reset, mul_signal} !== {1'b0, 1'b0, 1'b0, SIG_OUT}) begin
      n_fail++;
      $display("FAIL reset_ctrl: got busy=%b done=%b mul_reset=%b mul_signal=%h, expected 0 0 0 3f",
               busy, done, mul_reset, mul_signal);
    end
    n_checks++;
    if ({hi, lo, mul_dataA, mul_dataB} !== 128'b0) begin
      n_fail++;
      $display("FAIL reset_regs: got hi=%h lo=%h A=%h B=%h, expected all zero",
               hi, lo, mul_dataA, mul_dataB);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int lat, rc, mc;
    @(negedge clk);
    do_start(32'd3, 32'd5, F_MULTU, 1'b1);
    run_to_done(lat, rc, mc);
    n_checks++;
    if (lat !== 34) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d, expected 34", lat);
    end
    n_checks++;
    if (rc !== 1 || mc !== 32) begin
      n_fail++;
      $display("FAIL basic_ctrl_cycles: got mul_reset=%0d MULTU=%0d, expected 1 and 32", rc, mc);
    end
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'hF || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: got hi=%h lo=%h busy=%b, expected 00000000 0000000f 0", hi, lo, busy);
    end
  endtask

  task automatic test_max();
    int lat, rc, mc;
    @(negedge clk);
    do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, F_MULTU, 1'b1);
    run_to_done(lat, rc, mc);
    n_checks++;
    if (lat !== 34 || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL max_result: got lat=%0d hi=%h lo=%h, expected 34 fffffffe 00000001", lat, hi, lo);
    end
    funct = F_MFHI;
    #1;
    n_checks++;
    if (dataOut !== 32'hFFFF_FFFE) begin
      n_fail++;
      $display("FAIL max_mfhi: got %h, expected fffffffe", dataOut);
    end
    funct = F_MFLO;
    #1;
    n_checks++;
    if (dataOut !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL max_mflo: got %h, expected 00000001", dataOut);
    end
    funct = F_MULTU;
    #1;
    n_checks++;
    if (dataOut !== 32'h0) begin
      n_fail++;
      $display("FAIL max_other_funct: got %h, expected 00000000", dataOut);
    end
    funct = 6'b0;
  endtask

  task automatic test_ignored();
    int lat, rc, mc;
    int bad;
    // Non-MULTU start in IDLE.
    @(negedge clk);
    do_start(32'd9, 32'd9, F_MFHI, 1'b0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy !== 1'b0 || mul_reset !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0 || mul_dataA !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL ignore_mfhi_start: got %0d busy cycles, A=%h, expected 0 and ffffffff", bad, mul_dataA);
    end
    // MULTU start while busy, sampled at E0+10.
    do_start(32'h1234, 32'h5678, F_MULTU, 1'b1);
    fork
      run_to_done(lat, rc, mc);
      begin
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        funct = F_MULTU;
        dataA = 32'hFFFF_FFFF;
        dataB = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        funct = 6'b0;
        n_checks++;
        if (mul_dataA !== 32'h1234 || mul_dataB !== 32'h5678 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL ignore_busy_operands: got A=%h B=%h busy=%b, expected 00001234 00005678 1",
                   mul_dataA, mul_dataB, busy);
        end
      end
    join
    n_checks++;
    if (lat !== 34 || hi !== 32'h0 || lo !== 32'h0626_0060) begin
      n_fail++;
      $display("FAIL ignore_busy_result: got lat=%0d hi=%h lo=%h, expected 34 00000000 06260060", lat, hi, lo);
    end
  endtask

  task automatic test_reset_mid();
    int lat, rc, mc;
    @(negedge clk);
    do_start(32'hDEAD, 32'hBEEF, F_MULTU, 1'b1);
    repeat (20) @(posedge clk);
    #2 reset = 1'b0;
    sb.delete();
    #1;
    n_checks++;
    if ({busy, done, mul_reset, mul_signal} !== {1'b0, 1'b0, 1'b0, SIG_OUT}) begin
      n_fail++;
      $display("FAIL abort_ctrl: got busy=%b done=%b mul_reset=%b mul_signal=%h, expected 0 0 0 3f",
               busy, done, mul_reset, mul_signal);
    end
    n_checks++;
    if ({hi, lo, mul_dataA, mul_dataB} !== 128'b0) begin
      n_fail++;
      $display("FAIL abort_regs: got hi=%h lo=%h A=%h B=%h, expected all zero", hi, lo, mul_dataA, mul_dataB);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_release: got busy=%b hi=%h lo=%h, expected 0 0 0", busy, hi, lo);
    end
    do_start(32'd7, 32'd6, F_MULTU, 1'b1);
    run_to_done(lat, rc, mc);
    n_checks++;
    if (lat !== 34 || hi !== 32'h0 || lo !== 32'd42) begin
      n_fail++;
      $display("FAIL abort_restart: got lat=%0d hi=%h lo=%0d, expected 34 0 42", lat, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int lat, rc, mc;
    @(negedge clk);
    do_start(32'd2, 32'd2, F_MULTU, 1'b1);
    run_to_done(lat, rc, mc);
    n_checks++;
    if (lat !== 34 || lo !== 32'd4) begin
      n_fail++;
      $display("FAIL b2b_first: got lat=%0d lo=%h, expected 34 00000004", lat, lo);
    end
    // Still in the done cycle: issue the second request.
    do_start(32'h1_0000, 32'h1_0000, F_MULTU, 1'b1);
    fork
      run_to_done(lat, rc, mc);
      begin
        repeat (5) @(negedge clk);
        funct = F_MFLO;
        #1;
        n_checks++;
        if (dataOut !== 32'd4 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_mflo_during_run: got dataOut=%h busy=%b, expected 00000004 1", dataOut, busy);
        end
        funct = 6'b0;
      end
    join
    n_checks++;
    if (lat !== 34 || hi !== 32'h1 || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL b2b_second: got lat=%0d hi=%h lo=%h, expected 34 00000001 00000000", lat, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_ignored();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending results, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
